// File: rtl/eth_decap.sv
// rtl/eth_decap.sv - MAC RX frame filter and TLP-over-Ethernet header strip (optional ETH_DECAP_STATS_EN statistics)
module eth_decap #(
    parameter logic [15:0] ETHERTYPE    = 16'h88B5,
    parameter bit          ACCEPT_BCAST = 1'b1
) (
    input  logic        clk156,
    input  logic        sys_rst,
    input  logic        s_axis_rx_tvalid,
    input  logic [63:0] s_axis_rx_tdata,
    input  logic [7:0]  s_axis_rx_tkeep,
    input  logic        s_axis_rx_tlast,
    input  logic        s_axis_rx_tuser,
    input  logic [47:0] local_mac,
    output logic        wr_en,
    output logic [73:0] din,
    input  logic        full,
    output logic [31:0] frame_cnt,
    output logic [31:0] drop_cnt,
    output logic [31:0] err_cnt,
    output logic [31:0] seq_gap_cnt,
    output logic [15:0] last_seq
);

    typedef enum logic [2:0] {SYNC, HDR0, HDR1, PAYLOAD, DISCARD} state_t;

    state_t      state, state_nxt;
    logic        dst_ok, dst_ok_nxt;
    logic        term_pend, term_nxt;
    logic        wr_nxt;
    logic [73:0] din_nxt;
    logic        frame_inc, err_inc, drop_inc, seq_ld, frame_done;

    logic [47:0] rx_dst;
    logic [15:0] rx_type;
    logic        dst_hit;

    // Wire byte n sits in lane n, so multi-byte fields are byte-swapped out of tdata.
    assign rx_dst  = {s_axis_rx_tdata[7:0],   s_axis_rx_tdata[15:8],  s_axis_rx_tdata[23:16],
                      s_axis_rx_tdata[31:24], s_axis_rx_tdata[39:32], s_axis_rx_tdata[47:40]};
    assign rx_type = {s_axis_rx_tdata[39:32], s_axis_rx_tdata[47:40]};
    assign dst_hit = (rx_dst == local_mac) || (ACCEPT_BCAST && (rx_dst == 48'hFFFF_FFFF_FFFF));

    always_ff @(posedge clk156 or posedge sys_rst) begin
        if (sys_rst) begin
            state     <= SYNC;
            dst_ok    <= 1'b0;
            term_pend <= 1'b0;
            wr_en     <= 1'b0;
            din       <= '0;
        end else begin
            state     <= state_nxt;
            dst_ok    <= dst_ok_nxt;
            term_pend <= term_nxt;
            wr_en     <= wr_nxt;
            din       <= din_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        dst_ok_nxt = dst_ok;
        term_nxt   = term_pend;
        wr_nxt     = 1'b0;
        din_nxt    = din;
        frame_inc  = 1'b0;
        err_inc    = 1'b0;
        drop_inc   = 1'b0;
        seq_ld     = 1'b0;
        frame_done = 1'b0;

        // A pending error terminator wins the FIFO port over any payload beat.
        if (term_pend && !full) begin
            wr_nxt   = 1'b1;
            din_nxt  = {1'b1, 1'b1, 8'h00, 64'h0};
            term_nxt = 1'b0;
        end

        case (state)
            SYNC: begin
                if (!s_axis_rx_tvalid || s_axis_rx_tlast)
                    state_nxt = HDR0;
            end
            HDR0: begin
                if (s_axis_rx_tvalid) begin
                    if (s_axis_rx_tlast) begin
                        err_inc = 1'b1;
                    end else begin
                        dst_ok_nxt = dst_hit;
                        state_nxt  = HDR1;
                    end
                end
            end
            HDR1: begin
                if (s_axis_rx_tvalid) begin
                    if (s_axis_rx_tlast) begin
                        err_inc   = 1'b1;
                        state_nxt = HDR0;
                    end else if (!dst_ok || (rx_type != ETHERTYPE)) begin
                        drop_inc  = 1'b1;
                        state_nxt = DISCARD;
                    end else begin
                        seq_ld    = 1'b1;
                        state_nxt = PAYLOAD;
                    end
                end
            end
            PAYLOAD: begin
                if (s_axis_rx_tvalid) begin
                    // term_pend can only be set here on the first payload beat of a new frame.
                    if (term_pend) begin
                        drop_inc  = 1'b1;
                        state_nxt = s_axis_rx_tlast ? HDR0 : DISCARD;
                    end else if (full) begin
                        err_inc   = 1'b1;
                        term_nxt  = 1'b1;
                        state_nxt = s_axis_rx_tlast ? HDR0 : DISCARD;
                    end else begin
                        wr_nxt  = 1'b1;
                        din_nxt = {s_axis_rx_tlast & ~s_axis_rx_tuser, s_axis_rx_tlast,
                                   s_axis_rx_tkeep, s_axis_rx_tdata};
                        if (s_axis_rx_tlast) begin
                            frame_done = 1'b1;
                            frame_inc  = s_axis_rx_tuser;
                            err_inc    = ~s_axis_rx_tuser;
                            state_nxt  = HDR0;
                        end
                    end
                end
            end
            DISCARD: begin
                if (s_axis_rx_tvalid && s_axis_rx_tlast)
                    state_nxt = HDR0;
            end
            default: state_nxt = SYNC;
        endcase
    end

`ifdef ETH_DECAP_STATS_EN
    logic [15:0] seq_r;
    logic        seen_frame;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge clk156 or posedge sys_rst) begin
        if (sys_rst) begin
            seq_r       <= '0;
            seen_frame  <= 1'b0;
            frame_cnt   <= '0;
            drop_cnt    <= '0;
            err_cnt     <= '0;
            seq_gap_cnt <= '0;
            last_seq    <= '0;
        end else begin
            if (seq_ld)
                seq_r <= {s_axis_rx_tdata[55:48], s_axis_rx_tdata[63:56]};
            if (frame_inc) frame_cnt <= sat_inc(frame_cnt);
            if (drop_inc)  drop_cnt  <= sat_inc(drop_cnt);
            if (err_inc)   err_cnt   <= sat_inc(err_cnt);
            if (frame_done) begin
                last_seq   <= seq_r;
                seen_frame <= 1'b1;
                if (seen_frame && (seq_r != last_seq + 16'd1))
                    seq_gap_cnt <= sat_inc(seq_gap_cnt);
            end
        end
    end
`else
    logic unused_events;
    assign unused_events = ^{frame_inc, err_inc, drop_inc, seq_ld, frame_done};
    assign frame_cnt     = '0;
    assign drop_cnt      = '0;
    assign err_cnt       = '0;
    assign seq_gap_cnt   = '0;
    assign last_seq      = '0;
`endif

endmodule

// File: tb/tb_eth_decap.sv
// tb/tb_eth_decap.sv - scoreboard bench for eth_decap: filtering, header strip, overflow terminator, statistics
module tb_eth_decap;

`ifdef ETH_DECAP_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif
    localparam logic [47:0] MAC   = 48'h02_11_22_33_44_55;
    localparam logic [47:0] BCAST = 48'hFFFF_FFFF_FFFF;

    logic        clk156 = 1'b0;
    logic        sys_rst = 1'b1;
    logic        tvalid = 1'b0, tlast = 1'b0, tuser = 1'b0, full = 1'b0;
    logic [63:0] tdata = '0;
    logic [7:0]  tkeep = '0;
    logic        wr_en;
    logic [73:0] din;
    logic [31:0] frame_cnt, drop_cnt, err_cnt, seq_gap_cnt;
    logic [15:0] last_seq;

    int          n_chk = 0, n_fail = 0;
    logic [73:0] exp_q[$];
    logic [73:0] e;
    int          m_frame, m_drop, m_err, m_gap;
    logic [15:0] m_last_seq;
    bit          m_seen;

    eth_decap #(.ETHERTYPE(16'h88B5), .ACCEPT_BCAST(1'b1)) dut (
        .clk156(clk156), .sys_rst(sys_rst),
        .s_axis_rx_tvalid(tvalid), .s_axis_rx_tdata(tdata), .s_axis_rx_tkeep(tkeep),
        .s_axis_rx_tlast(tlast), .s_axis_rx_tuser(tuser), .local_mac(MAC),
        .wr_en(wr_en), .din(din), .full(full),
        .frame_cnt(frame_cnt), .drop_cnt(drop_cnt), .err_cnt(err_cnt),
        .seq_gap_cnt(seq_gap_cnt), .last_seq(last_seq)
    );

    always #5 clk156 = ~clk156;

    always @(negedge clk156) begin
        if (wr_en) begin
            n_chk++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL fifo_write unexpected din=%h", din);
            end else begin
                e = exp_q.pop_front();
                if (din !== e) begin
                    n_fail++;
                    $display("FAIL fifo_write got %h exp %h", din, e);
                end
            end
        end
    end

    function automatic logic [31:0] ev(input int v);
        return STATS ? 32'(v) : 32'd0;
    endfunction

    task automatic beat(input logic [63:0] d, input logic [7:0] k, input logic l, input logic u, input bit gaps);
        tvalid = 1'b1; tdata = d; tkeep = k; tlast = l; tuser = u;
        @(posedge clk156); #1;
        tvalid = 1'b0; tlast = 1'b0;
        if (gaps && $urandom_range(0, 2) == 0) begin
            @(posedge clk156); #1;
        end
    endtask

    task automatic send_idle(input int n);
        tvalid = 1'b0; tlast = 1'b0;
        repeat (n) begin @(posedge clk156); #1; end
    endtask

    task automatic send_hdr(input logic [47:0] dst, input logic [15:0] et, input logic [15:0] seq, input bit gaps);
        logic [63:0] d;
        d = '0;
        for (int n = 0; n < 6; n++) d[8*n +: 8] = dst[47-8*n -: 8];
        d[63:48] = 16'hA1B2;
        beat(d, 8'hFF, 1'b0, 1'b1, gaps);
        beat({seq[7:0], seq[15:8], et[7:0], et[15:8], 32'hC3D4E5F6}, 8'hFF, 1'b0, 1'b1, gaps);
    endtask

    task automatic send_frame(input logic [47:0] dst, input logic [15:0] et, input logic [15:0] seq,
                              input int npay, input logic user, input bit deliver, input bit gaps);
        logic [63:0] d;
        logic [7:0]  k;
        logic        l;
        send_hdr(dst, et, seq, gaps);
        for (int i = 0; i < npay; i++) begin
            d = {$urandom, $urandom};
            l = (i == npay - 1);
            k = l ? 8'h3F : 8'hFF;
            if (deliver) exp_q.push_back({l & ~user, l, k, d});
            beat(d, k, l, user, gaps);
        end
        if (deliver) begin
            if (user) m_frame++; else m_err++;
            if (m_seen && seq != m_last_seq + 16'd1) m_gap++;
            m_last_seq = seq;
            m_seen = 1'b1;
        end else begin
            m_drop++;
        end
    endtask

    task automatic do_reset();
        sys_rst = 1'b1;
        @(posedge clk156); #1;
        sys_rst = 1'b0;
        m_frame = 0; m_drop = 0; m_err = 0; m_gap = 0; m_last_seq = '0; m_seen = 1'b0;
        exp_q.delete();
        send_idle(2);
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk156); #1;
        n_chk++; if (wr_en !== 1'b0) begin n_fail++; $display("FAIL reset.wr_en got %b exp 0", wr_en); end
        n_chk++; if (din !== 74'h0) begin n_fail++; $display("FAIL reset.din got %h exp 0", din); end
        n_chk++; if ({frame_cnt, drop_cnt, err_cnt, seq_gap_cnt, last_seq} !== 144'h0) begin n_fail++; $display("FAIL reset.stats got %h exp 0", {frame_cnt, drop_cnt, err_cnt, seq_gap_cnt, last_seq}); end
        do_reset();
    endtask

    task automatic test_good_frame();
        send_frame(MAC, 16'h88B5, 16'd1, 4, 1'b1, 1'b1, 1'b0);
        send_idle(2);
        n_chk++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL good.pending got %0d exp 0", exp_q.size()); end
        n_chk++; if (frame_cnt !== ev(m_frame)) begin n_fail++; $display("FAIL good.frame_cnt got %0d exp %0d", frame_cnt, ev(m_frame)); end
        n_chk++; if (last_seq !== (STATS ? m_last_seq : 16'h0)) begin n_fail++; $display("FAIL good.last_seq got %0d exp %0d", last_seq, m_last_seq); end
        n_chk++; if (err_cnt !== ev(m_err)) begin n_fail++; $display("FAIL good.err_cnt got %0d exp %0d", err_cnt, ev(m_err)); end
    endtask

    task automatic test_reset_midframe();
        logic [63:0] d;
        send_hdr(MAC, 16'h88B5, 16'd2, 1'b0);
        d = {$urandom, $urandom};
        exp_q.push_back({1'b0, 1'b0, 8'hFF, d});
        beat(d, 8'hFF, 1'b0, 1'b1, 1'b0);
        @(negedge clk156); #1;
        sys_rst = 1'b1;
        #1;
        n_chk++; if (wr_en !== 1'b0 || din !== 74'h0) begin n_fail++; $display("FAIL midrst.async got wr_en=%b din=%h exp 0", wr_en, din); end
        n_chk++; if (frame_cnt !== 32'd0) begin n_fail++; $display("FAIL midrst.frame_cnt got %0d exp 0", frame_cnt); end
        m_frame = 0; m_drop = 0; m_err = 0; m_gap = 0; m_last_seq = '0; m_seen = 1'b0;
        @(posedge clk156); #1;
        sys_rst = 1'b0;
        for (int i = 0; i < 3; i++) beat({$urandom, $urandom}, 8'hFF, i == 2, 1'b1, 1'b0);
        send_idle(1);
        send_frame(MAC, 16'h88B5, 16'd10, 3, 1'b1, 1'b1, 1'b0);
        send_idle(2);
        n_chk++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL midrst.pending got %0d exp 0", exp_q.size()); end
        n_chk++; if (frame_cnt !== ev(m_frame)) begin n_fail++; $display("FAIL midrst.frame_cnt_after got %0d exp %0d", frame_cnt, ev(m_frame)); end
    endtask

    task automatic test_filter();
        send_frame(MAC, 16'h0800, 16'd11, 3, 1'b1, 1'b0, 1'b0);
        send_frame(48'h02_99_88_77_66_55, 16'h88B5, 16'd11, 3, 1'b1, 1'b0, 1'b0);
        send_frame(BCAST, 16'h88B5, 16'd11, 5, 1'b1, 1'b1, 1'b1);
        send_idle(2);
        n_chk++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL filter.pending got %0d exp 0", exp_q.size()); end
        n_chk++; if (drop_cnt !== ev(m_drop)) begin n_fail++; $display("FAIL filter.drop_cnt got %0d exp %0d", drop_cnt, ev(m_drop)); end
        n_chk++; if (frame_cnt !== ev(m_frame)) begin n_fail++; $display("FAIL filter.frame_cnt got %0d exp %0d", frame_cnt, ev(m_frame)); end
    endtask

    task automatic test_bad_fcs();
        send_frame(MAC, 16'h88B5, 16'd12, 3, 1'b0, 1'b1, 1'b0);
        send_idle(2);
        n_chk++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL badfcs.pending got %0d exp 0", exp_q.size()); end
        n_chk++; if (err_cnt !== ev(m_err)) begin n_fail++; $display("FAIL badfcs.err_cnt got %0d exp %0d", err_cnt, ev(m_err)); end
        n_chk++; if (frame_cnt !== ev(m_frame)) begin n_fail++; $display("FAIL badfcs.frame_cnt got %0d exp %0d", frame_cnt, ev(m_frame)); end
    endtask

    task automatic test_overflow();
        logic [63:0] d;
        send_hdr(MAC, 16'h88B5, 16'd13, 1'b0);
        for (int i = 0; i < 5; i++) begin
            d = {$urandom, $urandom};
            full = (i >= 1 && i <= 3);
            if (i == 0) begin
                exp_q.push_back({1'b0, 1'b0, 8'hFF, d});
                exp_q.push_back({1'b1, 1'b1, 8'h00, 64'h0});
            end
            beat(d, 8'hFF, i == 4, 1'b1, 1'b0);
        end
        full = 1'b0;
        m_err++;
        send_idle(2);
        n_chk++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL overflow.pending got %0d exp 0", exp_q.size()); end
        n_chk++; if (err_cnt !== ev(m_err)) begin n_fail++; $display("FAIL overflow.err_cnt got %0d exp %0d", err_cnt, ev(m_err)); end
        n_chk++; if (last_seq !== (STATS ? m_last_seq : 16'h0)) begin n_fail++; $display("FAIL overflow.last_seq got %0d exp %0d", last_seq, m_last_seq); end
    endtask

    task automatic test_term_pend_drop();
        logic [63:0] d;
        send_hdr(MAC, 16'h88B5, 16'd14, 1'b0);
        d = {$urandom, $urandom};
        exp_q.push_back({1'b0, 1'b0, 8'hFF, d});
        exp_q.push_back({1'b1, 1'b1, 8'h00, 64'h0});
        beat(d, 8'hFF, 1'b0, 1'b1, 1'b0);
        full = 1'b1;
        beat({$urandom, $urandom}, 8'hFF, 1'b1, 1'b1, 1'b0);
        send_hdr(MAC, 16'h88B5, 16'd15, 1'b0);
        beat({$urandom, $urandom}, 8'hFF, 1'b0, 1'b1, 1'b0);
        full = 1'b0;
        beat({$urandom, $urandom}, 8'hFF, 1'b0, 1'b1, 1'b0);
        beat({$urandom, $urandom}, 8'hFF, 1'b1, 1'b1, 1'b0);
        m_err++; m_drop++;
        send_idle(2);
        n_chk++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL termdrop.pending got %0d exp 0", exp_q.size()); end
        n_chk++; if (drop_cnt !== ev(m_drop)) begin n_fail++; $display("FAIL termdrop.drop_cnt got %0d exp %0d", drop_cnt, ev(m_drop)); end
        n_chk++; if (err_cnt !== ev(m_err)) begin n_fail++; $display("FAIL termdrop.err_cnt got %0d exp %0d", err_cnt, ev(m_err)); end
    endtask

    task automatic test_seq();
        do_reset();
        send_frame(MAC, 16'h88B5, 16'd5, 2, 1'b1, 1'b1, 1'b0);
        send_frame(MAC, 16'h88B5, 16'd7, 2, 1'b1, 1'b1, 1'b0);
        send_idle(2);
        n_chk++; if (seq_gap_cnt !== ev(m_gap)) begin n_fail++; $display("FAIL seq.gap_5_7 got %0d exp %0d", seq_gap_cnt, ev(m_gap)); end
        send_frame(MAC, 16'h88B5, 16'hFFFF, 2, 1'b1, 1'b1, 1'b0);
        send_frame(MAC, 16'h88B5, 16'h0000, 2, 1'b1, 1'b1, 1'b0);
        send_idle(2);
        n_chk++; if (seq_gap_cnt !== ev(m_gap)) begin n_fail++; $display("FAIL seq.gap_wrap got %0d exp %0d", seq_gap_cnt, ev(m_gap)); end
        n_chk++; if (last_seq !== (STATS ? m_last_seq : 16'h0)) begin n_fail++; $display("FAIL seq.last_seq got %0d exp %0d", last_seq, m_last_seq); end
        n_chk++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL seq.pending got %0d exp 0", exp_q.size()); end
    endtask

    task automatic test_runts();
        beat(64'h0000_5544_3322_1102, 8'hFF, 1'b1, 1'b1, 1'b0);
        send_idle(1);
        beat(64'h0000_5544_3322_1102, 8'hFF, 1'b0, 1'b1, 1'b0);
        beat(64'h0100_B588_0000_0000, 8'hFF, 1'b1, 1'b1, 1'b0);
        m_err += 2;
        send_idle(2);
        n_chk++; if (err_cnt !== ev(m_err)) begin n_fail++; $display("FAIL runts.err_cnt got %0d exp %0d", err_cnt, ev(m_err)); end
        n_chk++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL runts.pending got %0d exp 0", exp_q.size()); end
    endtask

    task automatic test_back_to_back();
        send_frame(MAC, 16'h88B5, 16'd1, 4, 1'b1, 1'b1, 1'b0);
        send_frame(MAC, 16'h88B5, 16'd2, 1, 1'b1, 1'b1, 1'b0);
        send_frame(MAC, 16'h88B5, 16'd3, 6, 1'b1, 1'b1, 1'b0);
        send_idle(2);
        n_chk++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL b2b.pending got %0d exp 0", exp_q.size()); end
        n_chk++; if (frame_cnt !== ev(m_frame)) begin n_fail++; $display("FAIL b2b.frame_cnt got %0d exp %0d", frame_cnt, ev(m_frame)); end
        n_chk++; if (seq_gap_cnt !== ev(m_gap)) begin n_fail++; $display("FAIL b2b.gap_cnt got %0d exp %0d", seq_gap_cnt, ev(m_gap)); end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_reset_midframe();
        test_filter();
        test_bad_fcs();
        test_overflow();
        test_term_pend_drop();
        test_seq();
        test_runts();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
